// File: rtl/fifo_btn_ctrl_if.sv
// Signal bundle between the push-button controller and its debounce, FIFO and LED neighbours.
// master = controller side, slave = environment (debouncers, FIFO, display).
interface fifo_btn_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              wr_tick;
    logic              rd_tick;
    logic              wr_level;
    logic              rd_level;
    logic [DATA_W-1:0] sw_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_rd;
    logic [DATA_W-1:0] led_data;
    logic              overflow_err;
    logic              underflow_err;
    logic              busy;

    modport master (
        input  wr_tick, rd_tick, wr_level, rd_level, sw_data,
        input  fifo_full, fifo_empty, fifo_rdata,
        output fifo_wr, fifo_wdata, fifo_rd, led_data,
        output overflow_err, underflow_err, busy
    );

    modport slave (
        output wr_tick, rd_tick, wr_level, rd_level, sw_data,
        output fifo_full, fifo_empty, fifo_rdata,
        input  fifo_wr, fifo_wdata, fifo_rd, led_data,
        input  overflow_err, underflow_err, busy
    );
endinterface

// File: rtl/fifo_btn_ctrl.sv
// Push-button sequencer for the FIFO demo: button ticks -> one-cycle FIFO strobes, LED capture, error flags.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat synthetic ticks driven by the level inputs.
module fifo_btn_ctrl #(
    parameter int DATA_W        = 8,
    parameter int ERR_CYCLES    = 12_500_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input logic             clk,
    input logic             rst_n,
    fifo_btn_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(ERR_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, ERR} state_t;

    state_t            state_q, state_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              wr_req_tick, rd_req_tick;
    logic              wr_req, rd_req;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [1:0] level;
    logic [1:0] rep_tick;

    assign level = {bus.rd_level, bus.wr_level};

    // Index 0 = write button, 1 = read button; first repeat after the delay, then every period.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rep
            logic [REP_W-1:0] cnt_q, cnt_d;
            logic             armed_q, armed_d;
            logic [REP_W-1:0] target;

            assign target       = armed_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
            assign rep_tick[gi] = level[gi] && (cnt_q == target);

            always_comb begin
                cnt_d   = cnt_q;
                armed_d = armed_q;
                if (!level[gi]) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (rep_tick[gi]) begin
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    armed_q <= armed_d;
                end
            end
        end
    endgenerate

    assign wr_req_tick = bus.wr_tick | rep_tick[0];
    assign rd_req_tick = bus.rd_tick | rep_tick[1];
`else
    logic unused_levels;
    assign unused_levels = bus.wr_level ^ bus.rd_level;
    assign wr_req_tick   = bus.wr_tick;
    assign rd_req_tick   = bus.rd_tick;
`endif

    always_comb begin
        state_d   = state_q;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        fifo_wr_d = 1'b0;
        wdata_d   = wdata_q;
        led_d     = led_q;
        wr_req    = wr_req_tick | wr_pend_q;
        rd_req    = rd_req_tick | rd_pend_q;

        case (state_q)
            IDLE: begin
                // Write has priority; a simultaneous read waits in rd_pend.
                if (wr_req) begin
                    wr_pend_d = 1'b0;
                    if (rd_req_tick) rd_pend_d = 1'b1;
                    if (bus.fifo_full) begin
                        state_d   = ERR;
                        ovf_d     = 1'b1;
                        err_cnt_d = CNT_W'(ERR_CYCLES - 1);
                    end else begin
                        wdata_d = bus.sw_data;
                        state_d = WR;
                    end
                end else if (rd_req) begin
                    rd_pend_d = 1'b0;
                    if (bus.fifo_empty) begin
                        state_d   = ERR;
                        unf_d     = 1'b1;
                        err_cnt_d = CNT_W'(ERR_CYCLES - 1);
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                fifo_wr_d = 1'b1;
                state_d   = IDLE;
                if (wr_req_tick) wr_pend_d = 1'b1;
                if (rd_req_tick) rd_pend_d = 1'b1;
            end
            RD: begin
                state_d = RD_CAP;
                if (wr_req_tick) wr_pend_d = 1'b1;
                if (rd_req_tick) rd_pend_d = 1'b1;
            end
            RD_CAP: begin
                led_d   = bus.fifo_rdata;
                state_d = IDLE;
                if (wr_req_tick) wr_pend_d = 1'b1;
                if (rd_req_tick) rd_pend_d = 1'b1;
            end
            ERR: begin
                // Ticks are ignored here; pending flags survive the error window.
                if (err_cnt_q == '0) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    err_cnt_d = err_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            fifo_wr_q <= 1'b0;
            wdata_q   <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            fifo_wr_q <= fifo_wr_d;
            wdata_q   <= wdata_d;
            led_q     <= led_d;
        end
    end

    // The write strobe trails the WR state by one cycle, so busy covers it as well.
    assign bus.fifo_wr       = fifo_wr_q;
    assign bus.fifo_wdata    = wdata_q;
    assign bus.fifo_rd       = (state_q == RD);
    assign bus.led_data      = led_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
    assign bus.busy          = (state_q != IDLE) | fifo_wr_q;
endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Directed bench for fifo_btn_ctrl: cycle-scheduled reference model plus hand-computed spot checks.
module tb_fifo_btn_ctrl;
    localparam int NERR = 4;
    localparam int NC   = 512;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fifo_btn_ctrl_if #(.DATA_W(8)) bus ();

    fifo_btn_ctrl #(
        .DATA_W(8),
        .ERR_CYCLES(NERR),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    // Reference model: each accepted request books its output effects on future cycle slots.
    bit         e_wr[NC], e_rd[NC], e_busy[NC], e_ovf[NC], e_unf[NC], cap[NC];
    bit         s_wd_v[NC], s_led_v[NC];
    logic [7:0] s_wd[NC], s_led[NC];
    logic [7:0] m_wdata, m_led;
    int         cyc, free_at, err_until;
    bit         m_wp, m_rp;

    initial begin
        cyc = 0; free_at = 0; err_until = -1;
        m_wp = 0; m_rp = 0; m_wdata = 8'h00; m_led = 8'h00;
        total = 0; bad = 0;
    end

    task automatic model_reset(input int k);
        for (int i = k; i < NC; i++) begin
            e_wr[i] = 0; e_rd[i] = 0; e_busy[i] = 0; e_ovf[i] = 0; e_unf[i] = 0;
            cap[i] = 0; s_wd_v[i] = 0; s_led_v[i] = 0;
        end
        m_wdata = 8'h00; m_led = 8'h00; m_wp = 0; m_rp = 0;
        free_at = 0; err_until = -1;
    endtask

    task automatic book_err(input int k, input bit is_ovf);
        for (int i = k + 1; i <= k + NERR && i < NC; i++) begin
            e_busy[i] = 1;
            if (is_ovf) e_ovf[i] = 1; else e_unf[i] = 1;
        end
        free_at   = k + NERR + 1;
        err_until = k + NERR;
    endtask

    task automatic model_step(input int k);
        bit wr_r, rd_r;
        if (cap[k] && k + 1 < NC) begin
            s_led_v[k+1] = 1; s_led[k+1] = bus.fifo_rdata;
        end
        if (k < free_at) begin
            if (k > err_until) begin
                if (bus.wr_tick) m_wp = 1;
                if (bus.rd_tick) m_rp = 1;
            end
        end else begin
            wr_r = bus.wr_tick | m_wp;
            rd_r = bus.rd_tick | m_rp;
            if (wr_r) begin
                m_wp = 0;
                if (bus.rd_tick) m_rp = 1;
                if (bus.fifo_full) book_err(k, 1'b1);
                else if (k + 3 < NC) begin
                    s_wd_v[k+1] = 1; s_wd[k+1] = bus.sw_data;
                    e_busy[k+1] = 1; e_busy[k+2] = 1; e_wr[k+2] = 1;
                    free_at = k + 2;
                end
            end else if (rd_r) begin
                m_rp = 0;
                if (bus.fifo_empty) book_err(k, 1'b0);
                else if (k + 3 < NC) begin
                    e_rd[k+1] = 1; e_busy[k+1] = 1; e_busy[k+2] = 1; cap[k+2] = 1;
                    free_at = k + 3;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc < NC) begin
            if (!rst_n) begin
                model_reset(cyc);
                chk("rst_fifo_wr", bus.fifo_wr, 0);
                chk("rst_fifo_rd", bus.fifo_rd, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_ovf", bus.overflow_err, 0);
                chk("rst_unf", bus.underflow_err, 0);
                chk("rst_wdata", bus.fifo_wdata, 0);
                chk("rst_led", bus.led_data, 0);
            end else begin
                if (s_wd_v[cyc]) m_wdata = s_wd[cyc];
                if (s_led_v[cyc]) m_led = s_led[cyc];
                chk("fifo_wr", bus.fifo_wr, e_wr[cyc]);
                chk("fifo_rd", bus.fifo_rd, e_rd[cyc]);
                chk("busy", bus.busy, e_busy[cyc]);
                chk("overflow_err", bus.overflow_err, e_ovf[cyc]);
                chk("underflow_err", bus.underflow_err, e_unf[cyc]);
                chk("fifo_wdata", bus.fifo_wdata, m_wdata);
                chk("led_data", bus.led_data, m_led);
                model_step(cyc);
            end
        end
        cyc++;
    end

    task automatic nxt(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.wr_tick = 0; bus.rd_tick = 0; bus.wr_level = 0; bus.rd_level = 0;
        bus.sw_data = 8'h00; bus.fifo_full = 0; bus.fifo_empty = 1; bus.fifo_rdata = 8'h00;
        nxt(3);
        chk("reset_busy", bus.busy, 0);
        chk("reset_led", bus.led_data, 8'h00);
        rst_n = 1'b1;
        nxt(2);

        // 1: plain write, strobe two cycles after the tick
        bus.sw_data = 8'hA5; bus.wr_tick = 1; nxt(1); bus.wr_tick = 0; bus.sw_data = 8'h5A;
        chk("t1_wr_p1", bus.fifo_wr, 0); chk("t1_busy_p1", bus.busy, 1);
        nxt(1);
        chk("t1_wr_p2", bus.fifo_wr, 1); chk("t1_wdata", bus.fifo_wdata, 8'hA5); chk("t1_busy_p2", bus.busy, 1);
        nxt(1);
        chk("t1_wr_p3", bus.fifo_wr, 0); chk("t1_busy_p3", bus.busy, 0); chk("t1_wdata_hold", bus.fifo_wdata, 8'hA5);
        nxt(2);

        // 2: read, data valid only in the cycle after the strobe
        bus.fifo_empty = 0; bus.rd_tick = 1; nxt(1); bus.rd_tick = 0;
        chk("t2_rd_p1", bus.fifo_rd, 1); chk("t2_wr_p1", bus.fifo_wr, 0);
        nxt(1); bus.fifo_rdata = 8'h3C;
        chk("t2_rd_p2", bus.fifo_rd, 0);
        nxt(1); bus.fifo_rdata = 8'h77;
        chk("t2_led_p3", bus.led_data, 8'h3C); chk("t2_busy_p3", bus.busy, 0);
        nxt(2);

        // 3: underflow, write tick during the error window is dropped
        bus.fifo_empty = 1; bus.rd_tick = 1; nxt(1); bus.rd_tick = 0;
        chk("t3_unf_p1", bus.underflow_err, 1); chk("t3_rd_p1", bus.fifo_rd, 0);
        bus.wr_tick = 1; nxt(1); bus.wr_tick = 0;
        chk("t3_unf_p2", bus.underflow_err, 1);
        nxt(2);
        chk("t3_unf_p4", bus.underflow_err, 1);
        nxt(1);
        chk("t3_unf_p5", bus.underflow_err, 0); chk("t3_busy_p5", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_wr", bus.fifo_wr, 0);
            nxt(1);
        end
        chk("t3_led_kept", bus.led_data, 8'h3C);

        // 4: overflow, then a clean write once full clears
        bus.fifo_full = 1; bus.sw_data = 8'hEE; bus.wr_tick = 1; nxt(1); bus.wr_tick = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_ovf_win", bus.overflow_err, 1); chk("t4_no_wr", bus.fifo_wr, 0);
            nxt(1);
        end
        chk("t4_ovf_p5", bus.overflow_err, 0); chk("t4_wdata_kept", bus.fifo_wdata, 8'hA5);
        nxt(1);
        bus.fifo_full = 0; bus.sw_data = 8'hC3; bus.wr_tick = 1; nxt(1); bus.wr_tick = 0;
        nxt(1);
        chk("t4_wr_after", bus.fifo_wr, 1); chk("t4_wdata_after", bus.fifo_wdata, 8'hC3);
        nxt(2);

        // 5: simultaneous ticks, write first then pending read
        bus.fifo_empty = 0; bus.sw_data = 8'h11; bus.fifo_rdata = 8'h00;
        bus.wr_tick = 1; bus.rd_tick = 1; nxt(1); bus.wr_tick = 0; bus.rd_tick = 0;
        chk("t5_wr_p1", bus.fifo_wr, 0); chk("t5_busy_p1", bus.busy, 1);
        nxt(1);
        chk("t5_wr_p2", bus.fifo_wr, 1); chk("t5_rd_p2", bus.fifo_rd, 0); chk("t5_wdata", bus.fifo_wdata, 8'h11);
        nxt(1);
        chk("t5_rd_p3", bus.fifo_rd, 1); chk("t5_wr_p3", bus.fifo_wr, 0);
        nxt(1); bus.fifo_rdata = 8'h96;
        nxt(1); bus.fifo_rdata = 8'h00;
        chk("t5_led_p5", bus.led_data, 8'h96);
        nxt(2);

        // 6: reset asserted in the middle of the RD cycle
        bus.rd_tick = 1; nxt(1); bus.rd_tick = 0;
        chk("t6_rd_before", bus.fifo_rd, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd_async", bus.fifo_rd, 0); chk("t6_busy_async", bus.busy, 0);
        chk("t6_led_async", bus.led_data, 8'h00); chk("t6_wdata_async", bus.fifo_wdata, 8'h00);
        chk("t6_errs_async", {bus.overflow_err, bus.underflow_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nxt(1);
            chk("t6_idle_rd", bus.fifo_rd, 0); chk("t6_idle_busy", bus.busy, 0);
        end

        // controller still works after reset
        bus.sw_data = 8'h42; bus.wr_tick = 1; nxt(1); bus.wr_tick = 0;
        nxt(1);
        chk("post_rst_wr", bus.fifo_wr, 1); chk("post_rst_wdata", bus.fifo_wdata, 8'h42);
        nxt(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_btn_ctrl.md
Name: fifo_btn_ctrl

Overview:
Push-button controller that sequences the single-port FIFO in the FIFO demo. It converts debounced write/read button ticks into one-cycle FIFO write/read strobes, gated by full/empty. It captures popped data for the LED display and flags overflow/underflow attempts for a fixed display time. It sits between the two debounce instances and the FIFO.

Parameters:
DATA_W, 8, FIFO word width and switch/LED width
ERR_CYCLES, 12_500_000, cycles an error flag stays asserted (must be >= 1)
REPEAT_DELAY, 25_000_000, hold cycles before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 5_000_000, cycles between auto-repeat ops (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_tick  in  1  debounced write-button tick, one-cycle pulse
rd_tick  in  1  debounced read-button tick, one-cycle pulse
wr_level  in  1  debounced write-button level (used only with AUTO_REPEAT_EN)
rd_level  in  1  debounced read-button level (used only with AUTO_REPEAT_EN)
sw_data  in  DATA_W  switch value to push
fifo_full  in  1  FIFO full status
fifo_empty  in  1  FIFO empty status
fifo_rdata  in  DATA_W  FIFO read data, valid the cycle after fifo_rd
fifo_wr  out  1  FIFO write strobe, one cycle
fifo_wdata  out  DATA_W  registered write data
fifo_rd  out  1  FIFO read strobe, one cycle
led_data  out  DATA_W  last successfully popped word
overflow_err  out  1  write attempted while full
underflow_err  out  1  read attempted while empty
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. All outputs, pending flags and counters are 0. Assertion mid-operation aborts immediately; no strobe completes.
- States: IDLE, WR, RD, RD_CAP, ERR.
- IDLE, write request (wr_tick or wr_pend):
  - If fifo_full: go to ERR, set overflow_err.
  - Otherwise: register sw_data into fifo_wdata and go to WR.
- IDLE, read request (rd_tick or rd_pend):
  - If fifo_empty: go to ERR, set underflow_err.
  - Otherwise: go to RD.
- IDLE, both requests in the same cycle: write wins. The read is latched in rd_pend and served on the next return to IDLE.
- WR: fifo_wr=1 for exactly one cycle, then IDLE. Latency is tick -> fifo_wr two cycles later.
- RD: fifo_rd=1 for exactly one cycle, then RD_CAP.
- RD_CAP: led_data <= fifo_rdata, then IDLE. led_data updates three cycles after the tick.
- Ticks in WR/RD/RD_CAP set wr_pend/rd_pend, each one deep. Extra ticks while a flag is already set are dropped.
- Pending flags clear when serviced, including when the service ends in ERR.
- Full/empty are sampled only in IDLE at request time.
- ERR:
  - err_cnt loads ERR_CYCLES-1 on entry and decrements each cycle.
  - At 0: clear both error flags and go to IDLE.
  - Ticks arriving during ERR are dropped; existing pending flags are kept.
- err_cnt width is $clog2(ERR_CYCLES+1). There is no wrap: it only decrements when nonzero.
- fifo_wdata and led_data hold their values between updates. led_data is unchanged on underflow.
- fifo_wr and fifo_rd are never high in the same cycle.

Optional Feature:
AUTO_REPEAT_EN
- Defined: per button, a hold counter runs while the level input is high in IDLE or busy states.
  - After REPEAT_DELAY cycles of continuous hold, it injects a synthetic tick.
  - It then injects one every REPEAT_PERIOD cycles until the level drops. A level drop clears the counter.
  - Synthetic ticks obey the same pending, priority and ERR-drop rules as real ticks.
- Undefined: the level inputs are ignored (left unconnected internally) and no repeat logic is synthesized.

Test Plan:
1. ERR_CYCLES=4, empty FIFO, sw_data=8'hA5, wr_tick -> fifo_wr=1 exactly 2 cycles later with fifo_wdata=8'hA5; busy high for 2 cycles.
2. FIFO holds 8'h3C, rd_tick -> fifo_rd pulse at +1, led_data=8'h3C at +3; no other strobes.
3. fifo_empty=1, rd_tick -> underflow_err high for exactly 4 cycles; no fifo_rd; led_data unchanged; a wr_tick during ERR produces no fifo_wr.
4. fifo_full=1, wr_tick -> overflow_err high 4 cycles, fifo_wr never asserts. After clearing full and issuing a new wr_tick, the write proceeds.
5. wr_tick and rd_tick in the same cycle, FIFO non-empty, not full -> fifo_wr first; then fifo_rd serviced from rd_pend with no further tick; led_data updates.
6. rst_n pulled low in the RD cycle -> fifo_rd, busy, error flags and led_data are 0 asynchronously. After release the state is IDLE with no pending ops.
